mux4_scan_sequencer: RTL and testbench
======================================

Name: mux4_scan_sequencer

Overview:
Upstream controller for the 4:1 structural mux. It drives the mux select lines (s1, s0) through the enabled channels in ascending order. After a programmable settle time on each channel it samples the mux output, then presents all four samples as one parallel snapshot with a one-cycle valid strobe. It supports single-shot and continuous scanning, with a start/busy handshake toward the system.

Parameters:
SETTLE_CYCLES, 2, cycles a select value is held before sampling; legal 0..255.
CNT_W, derived (max(1, clog2(SETTLE_CYCLES+1))), settle counter width; not user-overridden.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a frame; honoured only when idle
continuous  input  1  when 1 at frame end, the next frame begins immediately
chan_en  input  4  per-channel enable (bit i = mux input Ii); latched at frame start
y_in  input  1  mux output y
s1  output  1  mux select MSB
s0  output  1  mux select LSB
samples  output  4  last completed snapshot; bit i = sample of channel i
sample_valid  output  1  one-cycle pulse when samples updates
busy  output  1  high while a frame is in progress

Behaviour:
- One clock domain. Reset is synchronous and active-high. All state changes occur on the rising edge of clk.
- Reset values: s1=0, s0=0, samples=4'b0000, sample_valid=0, busy=0, FSM=IDLE, working register=0, settle counter=0.
- FSM states: IDLE and SETTLE. Frame completion is a transition, not a state.
- IDLE:
  - {s1,s0}=2'b00; busy=0.
  - start=1 with chan_en!=0: on the next edge, latch chan_en, clear the working register, set {s1,s0} to the lowest enabled index, load counter=SETTLE_CYCLES, go to SETTLE, set busy=1.
  - start=1 with chan_en==0: ignored; stay in IDLE with no pulse.
- SETTLE:
  - While counter>0: decrement the counter; select lines are held.
  - When counter==0, on that edge: working[idx] <= y_in.
  - If a higher enabled channel exists: set the select to the next enabled index and reload counter=SETTLE_CYCLES.
  - Otherwise the frame ends: samples <= working with the new bit merged in, sample_valid <= 1 for exactly one cycle.
- Per-channel timing: each enabled channel occupies SETTLE_CYCLES+1 cycles. Disabled channels take no cycles and read 0 in samples.
- Frame end, continuous=0: go to IDLE; busy=0 and sample_valid=1 in the same cycle.
- Frame end, continuous=1:
  - Re-latch chan_en and clear the working register.
  - If chan_en!=0: select its lowest enabled index and stay in SETTLE; busy stays 1 and sample_valid=1 in that same cycle.
  - If chan_en==0: go to IDLE.
- start while busy: ignored. chan_en changes mid-frame take effect only at the next frame start.
- continuous is examined only at the frame-end edge. Deasserting it mid-frame completes the current frame, then the block idles.
- SETTLE_CYCLES=0: one cycle per channel; the sample is taken at the end of the cycle in which the select was first driven.
- rst asserted mid-frame: all outputs return to reset values on that edge. No sample_valid is produced, and the partial frame is discarded.
- rst and start in the same cycle: rst wins.
- samples holds its value between frames; it changes only on a sample_valid cycle.
- y_in is assumed stable by the sample edge; the block adds no synchronisers.

Test Plan:
- Reset: hold rst 2 cycles with start=1 -> s1,s0=00, samples=0000, busy=0, sample_valid=0 throughout.
- Single frame, SETTLE_CYCLES=2, chan_en=1111, mux I3..I0=1010, start pulsed in cycle 0:
  - select is 00 in cycles 1-3, 01 in 4-6, 10 in 7-9, 11 in 10-12.
  - Cycle 13: sample_valid=1, samples=1010, busy=0.
- Sparse enable, chan_en=0101, I3..I0=1111:
  - Only selects 00 and 10 appear, cycles 1-3 and 4-6.
  - Cycle 7: samples=0101, sample_valid=1.
  - chan_en=0000 with start -> no busy, no pulse.
- Continuous mode: continuous=1, chan_en=0011, I3..I0=0001.
  - After the first frame, change I0=0, I1=1 -> second frame gives samples=0010.
  - sample_valid pulses every 6 cycles with busy constantly 1.
  - Drop continuous -> busy falls together with the next pulse.
- Mid-frame events: start re-pulsed during busy -> timing unchanged. rst at cycle 5 of a frame -> outputs reset, no sample_valid, and the prior samples value is cleared to 0000.
- SETTLE_CYCLES=0 build, chan_en=1111, I3..I0=0110 -> selects change every cycle (cycles 1-4); sample_valid in cycle 5 with samples=0110.

Source files
------------

// File: rtl/mux4_scan_sequencer_if.sv
// Bus between the system, the 4:1 mux and the scan sequencer.
// The slave side is the sequencer and the master side is the system/mux.
interface mux4_scan_sequencer_if;
    logic       start;
    logic       continuous;
    logic [3:0] chan_en;
    logic       y_in;
    logic       s1;
    logic       s0;
    logic [3:0] samples;
    logic       sample_valid;
    logic       busy;

    modport slave (
        input  start, continuous, chan_en, y_in,
        output s1, s0, samples, sample_valid, busy
    );

    modport master (
        output start, continuous, chan_en, y_in,
        input  s1, s0, samples, sample_valid, busy
    );
endinterface

// File: rtl/mux4_scan_sequencer.sv
// Walks the 4:1 mux select through the enabled channels, samples each channel after a settle
// time, and publishes the four samples as one snapshot with a single-cycle valid strobe.
//
// state     | meaning
// ST_IDLE   | select parked at 00, waiting for start with a non-zero enable
// ST_SETTLE | holding the select on one channel; sample taken when counter hits 0
module mux4_scan_sequencer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    mux4_scan_sequencer_if.slave  bus
);
    localparam int CNT_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_SETTLE = 1'b1;

    logic [0:0]       r_state;
    logic [3:0]       r_en;
    logic [3:0]       r_work;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_sel;
    logic [3:0]       r_samples;
    logic             r_valid;

    logic [2:0]       w_first;
    logic [2:0]       w_next;
    logic [3:0]       w_work;

    // Returns {found, index} of the lowest enabled channel at or above 'from'.
    function automatic logic [2:0] f_find(input logic [3:0] en, input int from);
        logic [2:0] res;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (en[i] && (i >= from)) res = {1'b1, 2'(i)};
        end
        return res;
    endfunction

    always_comb begin
        w_first        = f_find(bus.chan_en, 0);
        w_next         = f_find(r_en, int'(r_sel) + 1);
        w_work         = r_work;
        w_work[r_sel]  = bus.y_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_en      <= 4'b0000;
            r_work    <= 4'b0000;
            r_cnt     <= '0;
            r_sel     <= 2'b00;
            r_samples <= 4'b0000;
            r_valid   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start && w_first[2]) begin
                        r_en    <= bus.chan_en;
                        r_work  <= 4'b0000;
                        r_sel   <= w_first[1:0];
                        r_cnt   <= CNT_LOAD;
                        r_state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else if (w_next[2]) begin
                        r_work <= w_work;
                        r_sel  <= w_next[1:0];
                        r_cnt  <= CNT_LOAD;
                    end else begin
                        r_samples <= w_work;
                        r_valid   <= 1'b1;
                        r_work    <= 4'b0000;
                        // Back-to-back frames re-latch the enable at the boundary.
                        if (bus.continuous) r_en <= bus.chan_en;
                        if (bus.continuous && w_first[2]) begin
                            r_sel <= w_first[1:0];
                            r_cnt <= CNT_LOAD;
                        end else begin
                            r_sel   <= 2'b00;
                            r_cnt   <= '0;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.s1           = r_sel[1];
    assign bus.s0           = r_sel[0];
    assign bus.samples      = r_samples;
    assign bus.sample_valid = r_valid;
    assign bus.busy         = (r_state == ST_SETTLE);
endmodule

// File: tb/tb_mux4_scan_sequencer.sv
// Scoreboard bench for mux4_scan_sequencer: two builds (settle 2 and settle 0) driven by
// directed frames; monitors pop expected {samples, busy} on every sample_valid pulse.
module tb_mux4_scan_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux4_scan_sequencer_if ifa ();
    mux4_scan_sequencer_if ifb ();

    logic [3:0] mux_a;
    logic [3:0] mux_b;
    assign ifa.y_in = mux_a[{ifa.s1, ifa.s0}];
    assign ifb.y_in = mux_b[{ifb.s1, ifb.s0}];

    mux4_scan_sequencer #(.SETTLE_CYCLES(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    mux4_scan_sequencer #(.SETTLE_CYCLES(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    int errors = 0;
    int checks = 0;
    logic [4:0] q_a[$];
    logic [4:0] q_b[$];
    logic [4:0] e_a;
    logic [4:0] e_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (ifa.sample_valid === 1'b1) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_a_unexpected: got pulse samples=%b, expected none at t=%0t",
                         ifa.samples, $time);
            end else begin
                e_a = q_a.pop_front();
                chk("sb_a_samples", 32'(ifa.samples), 32'(e_a[4:1]));
                chk("sb_a_busy", 32'(ifa.busy), 32'(e_a[0]));
            end
        end
    end

    always @(negedge clk) begin
        if (ifb.sample_valid === 1'b1) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_b_unexpected: got pulse samples=%b, expected none at t=%0t",
                         ifb.samples, $time);
            end else begin
                e_b = q_b.pop_front();
                chk("sb_b_samples", 32'(ifb.samples), 32'(e_b[4:1]));
                chk("sb_b_busy", 32'(ifb.busy), 32'(e_b[0]));
            end
        end
    end

    // One single-shot frame on the settle-2 build; each enabled channel holds its select 3 cycles.
    task automatic single_frame(input logic [3:0] en, input logic [3:0] mux,
                                input logic [3:0] exp, input bit disturb);
        int cyc;
        q_a.push_back({exp, 1'b0});
        mux_a          = mux;
        ifa.chan_en    = en;
        ifa.continuous = 1'b0;
        ifa.start      = 1'b1;
        tick();
        ifa.start = 1'b0;
        cyc = 1;
        for (int ch = 0; ch < 4; ch++) begin
            if (en[ch]) begin
                for (int k = 0; k < 3; k++) begin
                    chk("frame_sel", 32'({ifa.s1, ifa.s0}), 32'(ch));
                    chk("frame_busy", 32'(ifa.busy), 32'd1);
                    chk("frame_novalid", 32'(ifa.sample_valid), 32'd0);
                    ifa.start = disturb && (cyc == 4 || cyc == 8);
                    if (disturb && cyc == 2) ifa.chan_en = ~en;
                    tick();
                    cyc++;
                end
            end
        end
        ifa.start = 1'b0;
        chk("end_valid", 32'(ifa.sample_valid), 32'd1);
        chk("end_busy", 32'(ifa.busy), 32'd0);
        chk("end_sel", 32'({ifa.s1, ifa.s0}), 32'd0);
        tick();
        chk("after_valid", 32'(ifa.sample_valid), 32'd0);
        chk("after_hold", 32'(ifa.samples), 32'(exp));
    endtask

    typedef struct packed {
        logic [3:0] en;
        logic [3:0] mux;
        logic [3:0] exp;
        logic       disturb;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{en: 4'b1111, mux: 4'b1010, exp: 4'b1010, disturb: 1'b0};
        vecs[1] = '{en: 4'b0101, mux: 4'b1111, exp: 4'b0101, disturb: 1'b0};
        vecs[2] = '{en: 4'b1111, mux: 4'b0101, exp: 4'b0101, disturb: 1'b1};
        vecs[3] = '{en: 4'b1000, mux: 4'b1111, exp: 4'b1000, disturb: 1'b0};

        rst            = 1'b1;
        ifa.start      = 1'b1;
        ifa.continuous = 1'b0;
        ifa.chan_en    = 4'b1111;
        ifb.start      = 1'b0;
        ifb.continuous = 1'b0;
        ifb.chan_en    = 4'b0000;
        mux_a          = 4'b0000;
        mux_b          = 4'b0000;

        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_sel", 32'({ifa.s1, ifa.s0}), 32'd0);
            chk("rst_samples", 32'(ifa.samples), 32'd0);
            chk("rst_busy", 32'(ifa.busy), 32'd0);
            chk("rst_valid", 32'(ifa.sample_valid), 32'd0);
        end
        rst       = 1'b0;
        ifa.start = 1'b0;
        tick();

        foreach (vecs[i]) single_frame(vecs[i].en, vecs[i].mux, vecs[i].exp, vecs[i].disturb);

        // start with nothing enabled must not begin a frame
        ifa.chan_en = 4'b0000;
        ifa.start   = 1'b1;
        tick();
        ifa.start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("empty_busy", 32'(ifa.busy), 32'd0);
            chk("empty_valid", 32'(ifa.sample_valid), 32'd0);
            chk("empty_hold", 32'(ifa.samples), 32'b1000);
            tick();
        end

        // continuous: pulses in cycles 7, 13, 19; continuous dropped during the third frame
        q_a.push_back({4'b0001, 1'b1});
        q_a.push_back({4'b0010, 1'b1});
        q_a.push_back({4'b0010, 1'b0});
        mux_a          = 4'b0001;
        ifa.chan_en    = 4'b0011;
        ifa.continuous = 1'b1;
        ifa.start      = 1'b1;
        tick();
        ifa.start = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            chk("cont_busy", 32'(ifa.busy), 32'd1);
            chk("cont_valid", 32'(ifa.sample_valid), 32'((c == 7) || (c == 13)));
            if (c == 7) mux_a = 4'b0010;
            if (c == 14) ifa.continuous = 1'b0;
            tick();
        end
        chk("cont_end_busy", 32'(ifa.busy), 32'd0);
        chk("cont_end_valid", 32'(ifa.sample_valid), 32'd1);
        tick();

        // reset in cycle 5 of a frame discards it and clears the held snapshot
        mux_a       = 4'b1111;
        ifa.chan_en = 4'b1111;
        ifa.start   = 1'b1;
        tick();
        ifa.start = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_samples", 32'(ifa.samples), 32'd0);
        chk("midrst_busy", 32'(ifa.busy), 32'd0);
        chk("midrst_sel", 32'({ifa.s1, ifa.s0}), 32'd0);
        chk("midrst_valid", 32'(ifa.sample_valid), 32'd0);
        for (int c = 0; c < 12; c++) begin
            chk("midrst_idle", 32'(ifa.busy), 32'd0);
            tick();
        end

        // zero-settle build: one cycle per channel
        q_b.push_back({4'b0110, 1'b0});
        mux_b       = 4'b0110;
        ifb.chan_en = 4'b1111;
        ifb.start   = 1'b1;
        tick();
        ifb.start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk("z_sel", 32'({ifb.s1, ifb.s0}), 32'(c - 1));
            chk("z_busy", 32'(ifb.busy), 32'd1);
            tick();
        end
        chk("z_valid", 32'(ifb.sample_valid), 32'd1);
        chk("z_busy_end", 32'(ifb.busy), 32'd0);
        tick();
        chk("z_valid_off", 32'(ifb.sample_valid), 32'd0);
        tick();
        tick();

        chk("sb_a_drained", 32'(q_a.size()), 32'd0);
        chk("sb_b_drained", 32'(q_b.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
